// File: rtl/trim_slew_ctrl.sv
// Bandgap enable / trim sequencer: powers the bandgap up, slews trim changes one LSB
// at a time while it runs, and reports when the reference has settled at the requested code.
module trim_slew_ctrl #(
    parameter int                TRIM_W     = 8,
    parameter int                STEP_DIV   = 16,
    parameter int                SETTLE_CYC = 64,
    parameter logic [TRIM_W-1:0] TRIM_RST   = 8'h80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vddl,
    input  logic              vss,
    input  logic [TRIM_W-1:0] i_target,
    input  logic              i_load,
    input  logic              i_en_req,
    output logic [TRIM_W-1:0] o_trim,
    output logic              o_bg_en,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_done
);

    localparam int CNT_MAX = (STEP_DIV > SETTLE_CYC) ? STEP_DIV : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_STARTUP,
        S_RAMP,
        S_SETTLE,
        S_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TRIM_W-1:0] trim_q, trim_d;
    logic [TRIM_W-1:0] tgt_q, tgt_d;
    logic [TRIM_W-1:0] step_nxt;
    logic              bg_en_q, bg_en_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    // Supply pins exist only for the analog netlist.
    logic unused_pwr;
    assign unused_pwr = vddl ^ vss;

    function automatic logic [TRIM_W-1:0] step_toward(input logic [TRIM_W-1:0] cur,
                                                      input logic [TRIM_W-1:0] tgt);
        if (tgt > cur)      return cur + 1'b1;
        else if (tgt < cur) return cur - 1'b1;
        else                return cur;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            trim_q  <= TRIM_RST;
            tgt_q   <= TRIM_RST;
            bg_en_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trim_q  <= trim_d;
            tgt_q   <= tgt_d;
            bg_en_q <= bg_en_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // A load always lands in the target; direction uses the freshest target.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        trim_d   = trim_q;
        tgt_d    = i_load ? i_target : tgt_q;
        step_nxt = step_toward(trim_q, tgt_d);
        case (state_q)
            S_OFF: begin
                cnt_d = '0;
                if (i_load) trim_d = i_target;
                if (i_en_req) begin
                    state_d = S_STARTUP;
                    trim_d  = tgt_d;
                end
            end
            S_STARTUP: begin
                if (cnt_q == SETTLE_LAST)
                    state_d = (tgt_d != trim_q) ? S_RAMP : S_LOCKED;
            end
            S_RAMP: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d  = '0;
                    trim_d = step_nxt;
                    if (step_nxt == tgt_d) state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (i_load && (i_target != trim_q)) state_d = S_RAMP;
                else if (cnt_q == SETTLE_LAST)      state_d = S_LOCKED;
            end
            S_LOCKED: begin
                cnt_d = '0;
                if (i_load && (i_target != trim_q)) state_d = S_RAMP;
            end
            default: state_d = S_OFF;
        endcase
        // Disable overrides everything; the trim is frozen unless a load rides along.
        if ((state_q != S_OFF) && !i_en_req) begin
            state_d = S_OFF;
            trim_d  = i_load ? i_target : trim_q;
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        bg_en_d = (state_d != S_OFF);
        busy_d  = (state_d == S_STARTUP) || (state_d == S_RAMP) || (state_d == S_SETTLE);
        ready_d = (state_d == S_LOCKED);
        done_d  = (state_d == S_LOCKED) && (state_q != S_LOCKED);
    end

    assign o_trim  = trim_q;
    assign o_bg_en = bg_en_q;
    assign o_busy  = busy_q;
    assign o_ready = ready_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_trim_slew_ctrl.sv
// Bench for trim_slew_ctrl: directed scenarios plus random traffic, every cycle compared
// against a timestamp-based behavioural model of the sequencer.
module tb_trim_slew_ctrl;

    localparam int STEP_DIV   = 16;
    localparam int SETTLE_CYC = 64;
    localparam int TRIM_RST   = 8'h80;

    localparam int PH_OFF = 0, PH_STARTUP = 1, PH_RAMP = 2, PH_SETTLE = 3, PH_LOCKED = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vddl = 1'b1;
    logic       vss = 1'b0;
    logic [7:0] i_target = 8'h00;
    logic       i_load = 1'b0;
    logic       i_en_req = 1'b0;
    logic [7:0] o_trim;
    logic       o_bg_en, o_busy, o_ready, o_done;

    trim_slew_ctrl #(
        .TRIM_W(8), .STEP_DIV(STEP_DIV), .SETTLE_CYC(SETTLE_CYC), .TRIM_RST(8'h80)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vddl(vddl), .vss(vss),
        .i_target(i_target), .i_load(i_load), .i_en_req(i_en_req),
        .o_trim(o_trim), .o_bg_en(o_bg_en), .o_busy(o_busy),
        .o_ready(o_ready), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase plus absolute-cycle deadlines for the next step / end of wait.
    int m_trim, m_tgt, m_ph, m_done;
    int cyc = 0;
    int t_deadline, t_next_step;

    task automatic model_reset();
        m_trim = TRIM_RST;
        m_tgt  = TRIM_RST;
        m_ph   = PH_OFF;
        m_done = 0;
    endtask

    task automatic enter_ramp();
        m_ph        = PH_RAMP;
        t_next_step = cyc + STEP_DIV;
    endtask

    task automatic model_edge();
        int it;
        it     = int'(i_target);
        m_done = 0;
        cyc++;
        if (m_ph == PH_OFF) begin
            if (i_load) begin m_tgt = it; m_trim = it; end
            if (i_en_req) begin
                m_trim     = m_tgt;
                m_ph       = PH_STARTUP;
                t_deadline = cyc + SETTLE_CYC;
            end
        end else if (!i_en_req) begin
            m_ph = PH_OFF;
            if (i_load) begin m_tgt = it; m_trim = it; end
        end else begin
            if (i_load) m_tgt = it;
            case (m_ph)
                PH_STARTUP: if (cyc == t_deadline) begin
                    if (m_tgt != m_trim) enter_ramp();
                    else begin m_ph = PH_LOCKED; m_done = 1; end
                end
                PH_RAMP: if (cyc == t_next_step) begin
                    if (m_tgt > m_trim) m_trim++;
                    else if (m_tgt < m_trim) m_trim--;
                    t_next_step = cyc + STEP_DIV;
                    if (m_trim == m_tgt) begin
                        m_ph       = PH_SETTLE;
                        t_deadline = cyc + SETTLE_CYC;
                    end
                end
                PH_SETTLE: begin
                    if (i_load && it != m_trim) enter_ramp();
                    else if (cyc == t_deadline) begin m_ph = PH_LOCKED; m_done = 1; end
                end
                PH_LOCKED: if (i_load && it != m_trim) enter_ramp();
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".trim"},  32'(o_trim),  32'(m_trim));
        chk({tag, ".bg_en"}, 32'(o_bg_en), 32'(m_ph != PH_OFF));
        chk({tag, ".busy"},  32'(o_busy),
            32'(m_ph == PH_STARTUP || m_ph == PH_RAMP || m_ph == PH_SETTLE));
        chk({tag, ".ready"}, 32'(o_ready), 32'(m_ph == PH_LOCKED));
        chk({tag, ".done"},  32'(o_done),  32'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        check_all("cyc");
        i_load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input int v);
        i_target = 8'(v);
        i_load   = 1'b1;
        tick();
    endtask

    task automatic wait_locked(input string tag, input int budget);
        int n = 0;
        while (!o_ready && n < budget) begin tick(); n++; end
        chk({tag, ".locked"}, 32'(o_ready), 32'd1);
    endtask

    task automatic wait_trim(input string tag, input int v, input int budget);
        int n = 0;
        while (o_trim != 8'(v) && n < budget) begin tick(); n++; end
        chk({tag, ".reach"}, 32'(o_trim), 32'(v));
    endtask

    initial begin
        model_reset();
        run(2);
        chk("rst.trim", 32'(o_trim), 32'h80);
        chk("rst.bg_en", 32'(o_bg_en), 32'd0);
        rst_n = 1'b1;
        run(3);

        // Startup from reset
        i_en_req = 1'b1;
        tick();
        chk("start.bg_en", 32'(o_bg_en), 32'd1);
        chk("start.busy", 32'(o_busy), 32'd1);
        run(SETTLE_CYC - 1);
        chk("start.busy_end", 32'(o_busy), 32'd1);
        tick();
        chk("start.ready", 32'(o_ready), 32'd1);
        chk("start.done", 32'(o_done), 32'd1);
        chk("start.trim", 32'(o_trim), 32'h80);
        tick();
        chk("start.done_once", 32'(o_done), 32'd0);

        // Ramp up 0x80 -> 0x84
        load(8'h84);
        chk("up.ready_drop", 32'(o_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            run(STEP_DIV - 1);
            chk("up.hold", 32'(o_trim), 32'(8'h80 + k - 1));
            tick();
            chk("up.step", 32'(o_trim), 32'(8'h80 + k));
        end
        run(SETTLE_CYC - 1);
        chk("up.settling", 32'(o_busy), 32'd1);
        tick();
        chk("up.done", 32'(o_done), 32'd1);

        // Same-code load while locked
        load(8'h84);
        chk("same.ready", 32'(o_ready), 32'd1);
        chk("same.busy", 32'(o_busy), 32'd0);
        chk("same.done", 32'(o_done), 32'd0);
        run(4);

        // Retarget mid-ramp
        load(8'h80);
        wait_locked("back", 2000);
        load(8'h90);
        wait_trim("retgt", 8'h83, 200);
        load(8'h81);
        run(STEP_DIV - 2);
        tick();
        chk("retgt.step1", 32'(o_trim), 32'h82);
        run(STEP_DIV - 1);
        tick();
        chk("retgt.step2", 32'(o_trim), 32'h81);
        chk("retgt.settle", 32'(o_busy), 32'd1);
        wait_locked("retgt", 200);
        chk("retgt.done", 32'(o_done), 32'd1);

        // Disable mid-ramp, then load while off
        load(8'h90);
        wait_trim("dis", 8'h82, 200);
        i_en_req = 1'b0;
        tick();
        chk("dis.bg_en", 32'(o_bg_en), 32'd0);
        chk("dis.busy", 32'(o_busy), 32'd0);
        chk("dis.trim", 32'(o_trim), 32'h82);
        run(5);
        chk("dis.hold", 32'(o_trim), 32'h82);
        load(8'h10);
        chk("off.load", 32'(o_trim), 32'h10);
        i_en_req = 1'b1;
        tick();
        chk("reen.trim", 32'(o_trim), 32'h10);
        wait_locked("reen", 200);

        // Range extremes: ramp down to 0x00 and up to 0xFF
        load(8'h00);
        wait_locked("low", 2000);
        chk("low.trim", 32'(o_trim), 32'h00);
        i_en_req = 1'b0;
        load(8'hFD);
        i_en_req = 1'b1;
        tick();
        load(8'hFF);
        wait_locked("high", 2000);
        chk("high.trim", 32'(o_trim), 32'hFF);

        // Random traffic
        for (int c = 0; c < 6000; c++) begin
            if (i_en_req) begin
                if ($urandom_range(399) == 0) i_en_req = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                i_en_req = 1'b1;
            end
            if ($urandom_range(29) == 0) begin
                int t;
                if ($urandom_range(9) == 0) t = int'($urandom_range(255));
                else t = m_trim + int'($urandom_range(8)) - 4;
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                i_target = 8'(t);
                i_load   = 1'b1;
            end
            tick();
        end

        // Asynchronous reset mid-run
        i_en_req = 1'b1;
        load(8'h70);
        run(20);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        i_en_req = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trim_slew_ctrl.md
Name: trim_slew_ctrl

Overview:
Digital sequencer between the SPI trim register bank and the 3.3 V level shifters that drive the bandgap enable and 8-bit trim inputs. It owns the bandgap enable and the trim code the bandgap sees. Trim changes on a running bandgap are slewed one LSB at a time so the reference output never takes a large step. It flags when the reference has settled at the requested code. The block runs in the 1.8 V domain.

Parameters:
TRIM_W, 8, trim code width
STEP_DIV, 16, clocks between successive 1-LSB trim steps (>=1)
SETTLE_CYC, 64, clocks of settling wait after enable or after the final step (>=1)
TRIM_RST, 8'h80, trim code applied at reset (mid-scale)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
vddl  input  1  1.8 V supply pin, no logic function
vss  input  1  ground pin, no logic function
i_target  input  TRIM_W  requested trim code from the register bank
i_load  input  1  one-cycle strobe; captures i_target
i_en_req  input  1  level; 1 requests the bandgap on
o_trim  output  TRIM_W  trim code to the level shifters
o_bg_en  output  1  bandgap enable to the level shifter
o_busy  output  1  high in STARTUP, RAMP and SETTLE
o_ready  output  1  high only in LOCKED
o_done  output  1  one-cycle pulse on each entry to LOCKED

Behaviour:
- Reset (async assert, sync release): state=OFF, o_trim=TRIM_RST, target register=TRIM_RST, o_bg_en=0, o_busy=0, o_ready=0, o_done=0, counters=0.
- All outputs are registered.
- States: OFF, STARTUP, RAMP, SETTLE, LOCKED.
- OFF:
  - o_bg_en=0.
  - i_load sets target and o_trim to i_target on the next edge. There is no slewing while the bandgap is off.
  - i_en_req=1 moves to STARTUP. If i_load coincides, o_trim takes the new code in the same edge.
- STARTUP:
  - o_bg_en=1 from the first STARTUP cycle.
  - Counts SETTLE_CYC cycles, then moves to LOCKED.
  - i_load here updates target only. If the new target differs from o_trim, exit goes to RAMP instead of LOCKED.
- LOCKED:
  - o_ready=1.
  - i_load with i_target==o_trim: no state change, no o_done.
  - i_load with a different value: move to RAMP. o_ready drops in the cycle after the strobe.
- RAMP:
  - Step counter counts STEP_DIV cycles.
  - At each terminal count, o_trim moves one LSB toward target (+1 or -1).
  - The first step occurs STEP_DIV cycles after entering RAMP.
  - On the edge where o_trim becomes equal to target, move to SETTLE.
  - Arithmetic never wraps, since stepping is always toward target within 0..2^TRIM_W-1.
- SETTLE:
  - Counts SETTLE_CYC cycles, then LOCKED. o_done pulses in the first LOCKED cycle.
  - i_load with a code different from o_trim returns to RAMP and resets the step counter.
- Retarget mid-RAMP:
  - The target register updates immediately.
  - The direction is recomputed on every step.
  - The step counter is not reset, so the cadence is preserved.
- i_en_req=0 in any non-OFF state:
  - Next edge: state OFF, o_bg_en=0, o_busy=0, o_ready=0.
  - o_trim holds its current value.
  - The target register keeps its last value.
- A later i_en_req=1 restarts from STARTUP. If o_trim differs from target, OFF first snaps o_trim to target.
- Simultaneous i_en_req falling and i_load: disable wins for state. i_load still updates target and o_trim per OFF rules on the following cycle.
- Counters clear on every state entry.

Test Plan:
1. Reset check: rst_n low mid-run -> outputs return immediately to o_trim=0x80, bg_en=0, ready=0, busy=0.
2. Startup: i_en_req=1, no load -> o_bg_en=1 next edge, o_busy=1 for 64 cycles, then o_ready=1, single o_done pulse, o_trim stays 0x80.
3. Ramp up: LOCKED at 0x80, load 0x84 -> o_trim becomes 0x81/0x82/0x83/0x84 at 16/32/48/64 cycles after RAMP entry, then 64 settle cycles, then ready and done.
4. Retarget mid-ramp: ramping 0x80->0x90, at o_trim=0x83 load 0x81 -> next steps 0x82 then 0x81 on the 16-cycle cadence, then SETTLE and LOCKED.
5. Disable mid-ramp: at o_trim=0x82 drop i_en_req -> bg_en=0 and busy=0 next edge, o_trim holds 0x82. Then load 0x10 in OFF -> o_trim=0x10 directly with no stepping.
6. Same-code load in LOCKED: load value equal to o_trim -> ready stays 1, no busy, no o_done.
